mc_core_param: RTL and testbench
================================

MC_CORE_PARAM -- requirements
Module: mc_core_param

Interface
REQ-001 The block SHALL have these parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- ADDR_W, 32, width of mem_addr (low ADDR_W bits of the byte address).
- CNT_W, 32, width of retire_cnt.

REQ-002 The block SHALL have these ports:
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, synchronous active-high reset.
- mem_req, out, 1, memory access request.
- mem_we, out, 1, 1 = write, 0 = read; valid while mem_req=1.
- mem_addr, out, ADDR_W, byte address; word aligned.
- mem_wdata, out, 32, store data.
- mem_rdata, in, 32, read data; valid when mem_ready=1.
- mem_ready, in, 1, access completes this cycle.
- halted, out, 1, core stopped on an illegal opcode.
- pc_out, out, 32, current PC.
- retire_cnt, out, CNT_W, retired-instruction count.

Function
REQ-003 The block SHALL be a 32-bit MIPS multicycle core: one unified memory port, internal 32x32 register file, register $0 always reads 0 and ignores writes.
REQ-004 The block SHALL implement these instructions:
- add, sub, and, or, slt (R-type, opcode 0, funct 20/22/24/25/2A hex).
- lw (23), sw (2B), beq (04), bne (05), addi (08), j (02).
- Any other opcode or funct is illegal.
REQ-005 The FSM SHALL have these states: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, WB, BRANCH, JUMP, HALT.
REQ-006 FETCH SHALL behave as follows:
- mem_req=1, mem_we=0, mem_addr=PC.
- On mem_ready=1: IR<=mem_rdata, PC<=PC+4, go to DECODE.
- Otherwise hold FETCH with all request outputs unchanged.
REQ-007 DECODE SHALL latch A=rs and B=rt, compute the branch target PC+(sext(imm)<<2), and dispatch by opcode. An illegal opcode or funct SHALL go to HALT.
REQ-008 The non-memory paths SHALL be:
- R-type: EXEC_R -> WB; write to rd.
- addi: EXEC_I -> WB; write to rt.
- Immediate is sign-extended; arithmetic is 32-bit wrap-around, no overflow trap.
- slt is a signed compare.
REQ-009 The memory paths SHALL be:
- lw: MEM_ADDR (A+sext(imm)) -> MEM_RD -> MEM_WB; writes mem_rdata to rt.
- sw: MEM_ADDR -> MEM_WR; mem_we=1, mem_wdata=B.
- MEM_RD and MEM_WR hold until mem_ready=1.
- Address bits [1:0] are forced to 0.
REQ-010 The control-flow paths SHALL be:
- beq/bne: BRANCH; PC<=target if A==B (beq) or A!=B (bne), else unchanged.
- j: JUMP; PC<={PC[31:28], IR[25:0], 2'b00}.
- Both then go to FETCH.
REQ-011 With mem_ready tied to 1, the latency in cycles from FETCH entry to the next FETCH entry SHALL be:
- R-type 4, addi 4, lw 5, sw 4, beq 3, bne 3, j 3.
- Each wait cycle adds 1.
REQ-012 mem_req SHALL be 1 only in FETCH, MEM_RD and MEM_WR. While mem_req=1, mem_addr, mem_we and mem_wdata SHALL stay stable until the mem_ready cycle. mem_ready SHALL be ignored when mem_req=0.
REQ-013 retire_cnt SHALL increment by 1 when each legal instruction reaches its final state (WB, MEM_WB, MEM_WR, BRANCH, JUMP) and SHALL wrap at 2^CNT_W.
REQ-014 HALT SHALL be terminal: halted=1, mem_req=0, no PC, register or counter change until rst.
REQ-015 A write to $0 SHALL retire normally and leave $0=0.

Reset
REQ-016 rst=1 at a clock edge SHALL set:
- PC=RESET_PC; state=FETCH.
- All registers and IR = 0; retire_cnt=0; halted=0.
REQ-017 Outputs during rst=1 and in the first cycle after SHALL be: mem_req=1, mem_we=0, mem_addr=RESET_PC.
REQ-018 rst mid-transaction (any state, including a pending mem_req) SHALL abandon the access with no register or memory write.

Verification
REQ-019 mem_ready=1; program: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 -> $3=2, $4=1, retire_cnt=4 after 16 cycles.
REQ-020 sw $1,8($0) with $1=0xDEADBEEF, then lw $5,8($0) -> one write cycle with mem_addr=8, mem_wdata=0xDEADBEEF, mem_we=1; then $5=0xDEADBEEF; the lw takes 5 cycles.
REQ-021 mem_ready held 0 for 3 cycles during a lw MEM_RD -> mem_addr and mem_req are stable all 4 cycles; total lw latency is 8.
REQ-022 beq taken at PC=0x10 with imm=-4 -> next fetch at 0x04; bne with A==B -> next fetch at 0x14; j 0x40 -> next fetch at 0x100.
REQ-023 Opcode 0x3F fetched -> halted=1 two cycles after FETCH completes; mem_req stays 0 and retire_cnt is unchanged; rst then restarts the fetch at RESET_PC.
REQ-024 rst asserted while mem_req=1 in MEM_WR with mem_ready=0 -> no write accepted; next cycle state=FETCH, mem_addr=RESET_PC, retire_cnt=0.

Source files
------------

// File: rtl/mc_core_param.sv
// mc_core_param: multicycle MIPS subset core with a single unified memory port.
module mc_core_param #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int ADDR_W = 32,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [31:0]       pc_out,
  output logic [CNT_W-1:0]  retire_cnt
);
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, WB, BRANCH, JUMP, HALT
  } state_t;
  localparam logic [CNT_W-1:0] ONE = 1;
  state_t state, next_dec;
  logic [31:0] pc, ir, a, b, alu, mdr, target, alu_r, imm_sx, addr_al;
  logic [31:0] regs [32];
  logic [CNT_W-1:0] cnt;
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, dst;
  logic r_ok, unused_bits;
  assign op = ir[31:26];
  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign rd = ir[15:11];
  assign funct = ir[5:0];
  assign imm_sx = {{16{ir[15]}}, ir[15:0]};
  assign dst = op == 6'h00 ? rd : rt;
  assign r_ok = funct == 6'h20 || funct == 6'h22 || funct == 6'h24 || funct == 6'h25 || funct == 6'h2A;
  assign unused_bits = ^{ir[10:6], addr_al};
  always_comb begin
    alu_r = funct == 6'h22 ? a - b :
            funct == 6'h24 ? a & b :
            funct == 6'h25 ? a | b :
            funct == 6'h2A ? {31'b0, $signed(a) < $signed(b)} : a + b;
    next_dec = op == 6'h00 ? (r_ok ? EXEC_R : HALT) :
               (op == 6'h23 || op == 6'h2B) ? MEM_ADDR :
               (op == 6'h04 || op == 6'h05) ? BRANCH :
               op == 6'h08 ? EXEC_I :
               op == 6'h02 ? JUMP : HALT;
  end
  // Fetch uses the PC, data accesses the latched effective address; both word aligned.
  assign addr_al = {(state == FETCH ? pc[31:2] : alu[31:2]), 2'b00};
  assign mem_addr = addr_al[ADDR_W-1:0];
  assign mem_req = state == FETCH || state == MEM_RD || state == MEM_WR;
  assign mem_we = state == MEM_WR;
  assign mem_wdata = b;
  assign halted = state == HALT;
  assign pc_out = pc;
  assign retire_cnt = cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      ir <= '0;
      a <= '0;
      b <= '0;
      alu <= '0;
      mdr <= '0;
      target <= '0;
      cnt <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: if (mem_ready) begin
          ir <= mem_rdata;
          pc <= pc + 32'd4;
          state <= DECODE;
        end
        DECODE: begin
          a <= regs[rs];
          b <= regs[rt];
          target <= pc + {imm_sx[29:0], 2'b00};
          state <= next_dec;
        end
        EXEC_R: begin
          alu <= alu_r;
          state <= WB;
        end
        EXEC_I: begin
          alu <= a + imm_sx;
          state <= WB;
        end
        MEM_ADDR: begin
          alu <= a + imm_sx;
          state <= op == 6'h2B ? MEM_WR : MEM_RD;
        end
        MEM_RD: if (mem_ready) begin
          mdr <= mem_rdata;
          state <= MEM_WB;
        end
        MEM_WB: begin
          if (rt != 5'd0) regs[rt] <= mdr;
          cnt <= cnt + ONE;
          state <= FETCH;
        end
        MEM_WR: if (mem_ready) begin
          cnt <= cnt + ONE;
          state <= FETCH;
        end
        WB: begin
          if (dst != 5'd0) regs[dst] <= alu;
          cnt <= cnt + ONE;
          state <= FETCH;
        end
        // op[0] distinguishes bne from beq
        BRANCH: begin
          if ((a == b) ^ op[0]) pc <= target;
          cnt <= cnt + ONE;
          state <= FETCH;
        end
        JUMP: begin
          pc <= {pc[31:28], ir[25:0], 2'b00};
          cnt <= cnt + ONE;
          state <= FETCH;
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_core_param.sv
// tb_mc_core_param: directed programs with hand-computed results for mc_core_param.
module tb_mc_core_param;
  logic clk = 0, rst = 1, rdy = 1;
  logic mem_req, mem_we, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, retire_cnt;
  logic [31:0] mem [256];
  int n_chk = 0, n_err = 0, n_wr = 0, w0 = 0;
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[9:2]];
  mc_core_param dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(rdy), .halted(halted),
    .pc_out(pc_out), .retire_cnt(retire_cnt)
  );
  function automatic logic [31:0] ri(input logic [5:0] f, input logic [4:0] s, t, d);
    return {6'h00, s, t, d, 5'h00, f};
  endfunction
  function automatic logic [31:0] ii(input logic [5:0] op, input logic [4:0] s, t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Advance n clock edges from a negedge; the bench memory commits accepted writes.
  task automatic cyc(input int n);
    logic wp;
    logic [7:0] wa;
    logic [31:0] wd;
    repeat (n) begin
      wp = mem_req === 1'b1 && mem_we === 1'b1 && rdy && !rst;
      wa = mem_addr[9:2];
      wd = mem_wdata;
      @(posedge clk);
      if (wp) begin
        mem[wa] = wd;
        n_wr++;
      end
      @(negedge clk);
    end
  endtask
  task automatic clear();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask
  task automatic boot();
    rst = 1;
    rdy = 1;
    cyc(2);
    chk("rst_req", mem_req, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_we", mem_we, 0);
    rst = 0;
    chk("rst_cnt", retire_cnt, 0);
    chk("rst_halt", halted, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    // ALU program
    clear();
    mem[0] = ii(6'h08, 0, 1, 16'd5);
    mem[1] = ii(6'h08, 0, 2, 16'hFFFD);
    mem[2] = ri(6'h20, 1, 2, 3);
    mem[3] = ri(6'h2A, 2, 1, 4);
    mem[4] = ri(6'h22, 1, 2, 5);
    mem[5] = ri(6'h24, 1, 2, 6);
    mem[6] = ri(6'h25, 1, 2, 7);
    mem[7] = ri(6'h2A, 1, 2, 8);
    mem[8] = ri(6'h20, 1, 1, 0);
    mem[9] = ii(6'h2B, 0, 3, 16'h100);
    mem[10] = ii(6'h2B, 0, 4, 16'h104);
    mem[11] = ii(6'h2B, 0, 5, 16'h108);
    mem[12] = ii(6'h2B, 0, 6, 16'h10C);
    mem[13] = ii(6'h2B, 0, 7, 16'h110);
    mem[14] = ii(6'h2B, 0, 8, 16'h114);
    mem[15] = ii(6'h2B, 0, 0, 16'h118);
    mem[16] = ii(6'h2B, 0, 2, 16'h11E);
    mem[17] = 32'hFC00_0000;
    mem[69] = 32'h77;
    mem[70] = 32'h55;
    boot();
    cyc(16);
    chk("a_cnt16", retire_cnt, 4);
    chk("a_pc16", pc_out, 32'h10);
    chk("a_addr16", mem_addr, 32'h10);
    for (int i = 0; i < 100 && !halted; i++) cyc(1);
    chk("a_halt", halted, 1);
    chk("a_add", mem[64], 32'd2);
    chk("a_slt1", mem[65], 32'd1);
    chk("a_sub", mem[66], 32'd8);
    chk("a_and", mem[67], 32'd5);
    chk("a_or", mem[68], 32'hFFFF_FFFD);
    chk("a_slt0", mem[69], 32'd0);
    chk("a_r0", mem[70], 32'd0);
    chk("a_align", mem[71], 32'hFFFF_FFFD);
    cyc(4);
    chk("a_cnt", retire_cnt, 17);
    chk("a_pc", pc_out, 32'h48);
    chk("a_req", mem_req, 0);
    // Load/store program with wait states
    clear();
    mem[0] = {6'h02, 26'd4};
    mem[4] = ii(6'h23, 0, 1, 16'h200);
    mem[5] = ii(6'h2B, 0, 1, 16'h008);
    mem[6] = ii(6'h23, 0, 5, 16'h008);
    mem[7] = ii(6'h2B, 0, 5, 16'h300);
    mem[8] = ii(6'h23, 0, 6, 16'h200);
    mem[9] = ii(6'h2B, 0, 6, 16'h304);
    mem[10] = 32'hFC00_0000;
    mem[128] = 32'hDEAD_BEEF;
    boot();
    cyc(3);
    chk("b_j", mem_addr, 32'h10);
    cyc(5);
    chk("b_lw_lat", mem_addr, 32'h14);
    cyc(3);
    chk("b_sw_req", mem_req, 1);
    chk("b_sw_we", mem_we, 1);
    chk("b_sw_addr", mem_addr, 32'h8);
    chk("b_sw_data", mem_wdata, 32'hDEAD_BEEF);
    w0 = n_wr;
    cyc(1);
    chk("b_sw_one", n_wr - w0, 1);
    chk("b_sw_mem", mem[2], 32'hDEAD_BEEF);
    chk("b_sw_lat", mem_addr, 32'h18);
    cyc(5);
    chk("b_lw5", mem_addr, 32'h1C);
    cyc(4);
    chk("b_lw_val", mem[192], 32'hDEAD_BEEF);
    cyc(3);
    rdy = 0;
    chk("b_wait_addr", mem_addr, 32'h200);
    chk("b_wait_req", mem_req, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("b_hold_addr", mem_addr, 32'h200);
      chk("b_hold_req", mem_req, 1);
      chk("b_hold_we", mem_we, 0);
    end
    rdy = 1;
    cyc(2);
    chk("b_lw8", mem_addr, 32'h24);
    cyc(4);
    chk("b_lw_wait_val", mem[193], 32'hDEAD_BEEF);
    chk("b_cnt", retire_cnt, 7);
    // Control flow program
    clear();
    mem[0] = ii(6'h08, 0, 1, 16'd1);
    mem[1] = ii(6'h04, 2, 1, 16'd6);
    mem[2] = ii(6'h08, 0, 2, 16'd1);
    mem[3] = ri(6'h20, 0, 0, 0);
    mem[4] = ii(6'h04, 0, 0, 16'hFFFC);
    mem[8] = ii(6'h05, 1, 1, 16'd5);
    mem[9] = {6'h02, 26'h40};
    mem[64] = 32'hFC00_0000;
    boot();
    cyc(4);
    chk("c_addi", mem_addr, 32'h04);
    cyc(3);
    chk("c_beq_nt", mem_addr, 32'h08);
    cyc(8);
    chk("c_at10", mem_addr, 32'h10);
    cyc(3);
    chk("c_beq_back", mem_addr, 32'h04);
    cyc(3);
    chk("c_beq_fwd", mem_addr, 32'h20);
    cyc(3);
    chk("c_bne_nt", mem_addr, 32'h24);
    cyc(3);
    chk("c_j", mem_addr, 32'h100);
    chk("c_cnt", retire_cnt, 8);
    cyc(1);
    chk("c_dec_halt", halted, 0);
    cyc(1);
    chk("c_halt", halted, 1);
    chk("c_halt_req", mem_req, 0);
    cyc(3);
    chk("c_halt_cnt", retire_cnt, 8);
    chk("c_halt_pc", pc_out, 32'h104);
    chk("c_halt_hold", halted, 1);
    rst = 1;
    cyc(1);
    rst = 0;
    chk("c_rst_addr", mem_addr, 0);
    chk("c_rst_req", mem_req, 1);
    chk("c_rst_halt", halted, 0);
    chk("c_rst_cnt", retire_cnt, 0);
    // Reset during a stalled store
    clear();
    mem[0] = ii(6'h08, 0, 1, 16'd9);
    mem[1] = ii(6'h2B, 0, 1, 16'h040);
    mem[16] = 32'h1234;
    boot();
    cyc(5);
    rdy = 0;
    cyc(2);
    chk("d_wr_we", mem_we, 1);
    chk("d_wr_addr", mem_addr, 32'h40);
    chk("d_wr_cnt", retire_cnt, 1);
    rst = 1;
    cyc(1);
    chk("d_rst_we", mem_we, 0);
    chk("d_rst_addr", mem_addr, 0);
    chk("d_rst_req", mem_req, 1);
    chk("d_rst_cnt", retire_cnt, 0);
    chk("d_rst_pc", pc_out, 0);
    chk("d_no_wr", mem[16], 32'h1234);
    rst = 0;
    rdy = 1;
    cyc(8);
    chk("d_rerun", mem[16], 32'd9);
    chk("d_rerun_cnt", retire_cnt, 2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
